// File: rtl/vdc_ram_sched.sv
// VDC video RAM slot scheduler: one RAM slot per enable tick, granted by fixed priority
// to display fetch, refresh, CPU or block engine; read data returns two clocks after the slot.
module vdc_ram_sched #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              newCol,
    input  logic              fetchCol,
    input  logic              hSyncStart,
    input  logic              reg_atr,
    input  logic [3:0]        reg_drr,
    input  logic [ADDR_W-1:0] char_addr,
    input  logic [ADDR_W-1:0] attr_addr,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic              cpu_ack,
    output logic [7:0]        cpu_dout,
    input  logic              blk_req,
    input  logic              blk_we,
    input  logic [ADDR_W-1:0] blk_addr,
    input  logic [7:0]        blk_din,
    output logic              blk_ack,
    output logic [7:0]        blk_dout,
    output logic              char_strobe,
    output logic [7:0]        char_data,
    output logic              attr_strobe,
    output logic [7:0]        attr_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout
);

    typedef enum logic [2:0] {IDLE, CHAR, ATTR, REFR, CPU, BLK} owner_t;

    owner_t     owner;
    owner_t     grant;
    owner_t     slot_owner;
    owner_t     resp_owner;
    logic       slot_we;
    logic       resp_we;
    logic [3:0] ref_cnt;
    logic [3:0] ref_eff;
    logic [7:0] ref_addr;
    logic       blk_turn;
    logic       cpu_busy;
    logic       blk_busy;
    logic       cpu_ok;
    logic       blk_ok;

    // A line-start strobe takes effect in the same slot, so the burst can begin at once
    assign ref_eff  = hSyncStart ? reg_drr : ref_cnt;
    assign cpu_busy = (slot_owner == CPU) || (resp_owner == CPU);
    assign blk_busy = (slot_owner == BLK) || (resp_owner == BLK);
    assign cpu_ok   = cpu_req && !cpu_busy;
    assign blk_ok   = blk_req && !blk_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner <= IDLE;
        end else if (enable) begin
            owner <= grant;
        end
    end

    always_comb begin
        grant = IDLE;
        if (newCol && fetchCol) begin
            grant = CHAR;
        end else if (owner == CHAR && reg_atr) begin
            grant = ATTR;
        end else if (ref_eff != 4'd0) begin
            grant = REFR;
        end else if (cpu_ok && !(blk_ok && blk_turn)) begin
            grant = CPU;
        end else if (blk_ok) begin
            grant = BLK;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_din    <= '0;
            slot_owner <= IDLE;
            slot_we    <= 1'b0;
            ref_cnt    <= '0;
            ref_addr   <= '0;
            blk_turn   <= 1'b0;
        end else begin
            ram_we     <= 1'b0;
            slot_owner <= IDLE;
            slot_we    <= 1'b0;
            if (enable) begin
                slot_owner <= grant;
                ref_cnt    <= ref_eff;
                case (grant)
                    CHAR: ram_addr <= char_addr;
                    ATTR: ram_addr <= attr_addr;
                    REFR: begin
                        ram_addr <= {{(ADDR_W-8){1'b0}}, ref_addr};
                        ref_cnt  <= ref_eff - 4'd1;
                        ref_addr <= ref_addr + 8'd1;
                    end
                    CPU: begin
                        ram_addr <= cpu_addr;
                        ram_we   <= cpu_we;
                        slot_we  <= cpu_we;
                        if (cpu_we) ram_din <= cpu_din;
                        blk_turn <= 1'b1;
                    end
                    BLK: begin
                        ram_addr <= blk_addr;
                        ram_we   <= blk_we;
                        slot_we  <= blk_we;
                        if (blk_we) ram_din <= blk_din;
                        blk_turn <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Response stage runs every clock so delivery does not depend on later enables
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_owner  <= IDLE;
            resp_we     <= 1'b0;
            char_strobe <= 1'b0;
            attr_strobe <= 1'b0;
            cpu_ack     <= 1'b0;
            blk_ack     <= 1'b0;
            char_data   <= '0;
            attr_data   <= '0;
            cpu_dout    <= '0;
            blk_dout    <= '0;
        end else begin
            resp_owner  <= slot_owner;
            resp_we     <= slot_we;
            char_strobe <= (resp_owner == CHAR);
            attr_strobe <= (resp_owner == ATTR);
            cpu_ack     <= (resp_owner == CPU);
            blk_ack     <= (resp_owner == BLK);
            if (resp_owner == CHAR) char_data <= ram_dout;
            if (resp_owner == ATTR) attr_data <= ram_dout;
            if (resp_owner == CPU && !resp_we) cpu_dout <= ram_dout;
            if (resp_owner == BLK && !resp_we) blk_dout <= ram_dout;
        end
    end

endmodule

// File: tb/tb_vdc_ram_sched.sv
// Self-checking bench for vdc_ram_sched: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the slot scheduler.
module tb_vdc_ram_sched;

    localparam int ADDR_W = 16;
    localparam int K_IDLE = 0, K_CHAR = 1, K_ATTR = 2, K_REFR = 3, K_CPU = 4, K_BLK = 5;

    logic              clk;
    logic              reset;
    logic              enable, newCol, fetchCol, hSyncStart, reg_atr;
    logic [3:0]        reg_drr;
    logic [ADDR_W-1:0] char_addr, attr_addr, cpu_addr, blk_addr, ram_addr;
    logic              cpu_req, cpu_we, cpu_ack, blk_req, blk_we, blk_ack;
    logic [7:0]        cpu_din, cpu_dout, blk_din, blk_dout;
    logic              char_strobe, attr_strobe, ram_we;
    logic [7:0]        char_data, attr_data, ram_din, ram_dout;

    int checks = 0;
    int errors = 0;

    vdc_ram_sched #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .newCol(newCol), .fetchCol(fetchCol),
        .hSyncStart(hSyncStart), .reg_atr(reg_atr), .reg_drr(reg_drr),
        .char_addr(char_addr), .attr_addr(attr_addr),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .blk_req(blk_req), .blk_we(blk_we), .blk_addr(blk_addr), .blk_din(blk_din),
        .blk_ack(blk_ack), .blk_dout(blk_dout),
        .char_strobe(char_strobe), .char_data(char_data),
        .attr_strobe(attr_strobe), .attr_data(attr_data),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous video RAM attached to the scheduler
    logic [7:0] ram_mem [0:65535];
    always @(posedge clk) begin
        ram_dout <= ram_mem[ram_addr];
        if (ram_we) ram_mem[ram_addr] <= ram_din;
    end

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
    endfunction

    // Reference model: decides each slot's owner from the priority rules, keeps its own
    // copy of memory contents and a queue of responses due two clocks after each slot.
    typedef struct {
        int unsigned due;
        int          kind;
        bit          we;
        logic [7:0]  data;
    } txn_t;

    txn_t              pend[$];
    logic [7:0]        model_mem [0:65535];
    int unsigned       cyc = 0;
    int                m_ref = 0;
    int                m_refaddr = 0;
    bit                m_prev_char = 0, m_blk_turn = 0, m_cpu_wait = 0, m_blk_wait = 0;
    logic [ADDR_W-1:0] e_addr = '0;
    logic              e_we = 0, e_cs = 0, e_as = 0, e_ca = 0, e_ba = 0;
    logic [7:0]        e_din = '0, e_cd = '0, e_ad = '0, e_cpud = '0, e_blkd = '0;

    always @(posedge clk) begin : model
        int   g;
        int   refs;
        bit   cpuOk, blkOk;
        txn_t t;
        cyc++;
        if (reset) begin
            pend.delete();
            m_ref = 0; m_refaddr = 0; m_prev_char = 0; m_blk_turn = 0;
            m_cpu_wait = 0; m_blk_wait = 0;
            e_addr = '0; e_we = 0; e_din = '0;
            e_cs = 0; e_as = 0; e_ca = 0; e_ba = 0;
            e_cd = '0; e_ad = '0; e_cpud = '0; e_blkd = '0;
        end else begin
            e_we = 0;
            if (enable) begin
                refs  = hSyncStart ? int'(reg_drr) : m_ref;
                cpuOk = cpu_req && !m_cpu_wait;
                blkOk = blk_req && !m_blk_wait;
                g = K_IDLE;
                if (newCol && fetchCol) g = K_CHAR;
                else if (m_prev_char && reg_atr) g = K_ATTR;
                else if (refs > 0) g = K_REFR;
                else if (cpuOk && blkOk) g = m_blk_turn ? K_BLK : K_CPU;
                else if (cpuOk) g = K_CPU;
                else if (blkOk) g = K_BLK;
                m_prev_char = (g == K_CHAR);
                m_ref = (g == K_REFR) ? refs - 1 : refs;
                t.due = cyc + 2; t.kind = g; t.we = 0; t.data = '0;
                case (g)
                    K_CHAR: begin e_addr = char_addr; t.data = model_mem[char_addr]; end
                    K_ATTR: begin e_addr = attr_addr; t.data = model_mem[attr_addr]; end
                    K_REFR: begin
                        e_addr = ADDR_W'(m_refaddr);
                        m_refaddr = (m_refaddr + 1) % 256;
                    end
                    K_CPU: begin
                        e_addr = cpu_addr; t.we = cpu_we; m_cpu_wait = 1; m_blk_turn = 1;
                        if (cpu_we) begin e_we = 1; e_din = cpu_din; model_mem[cpu_addr] = cpu_din; end
                        else t.data = model_mem[cpu_addr];
                    end
                    K_BLK: begin
                        e_addr = blk_addr; t.we = blk_we; m_blk_wait = 1; m_blk_turn = 0;
                        if (blk_we) begin e_we = 1; e_din = blk_din; model_mem[blk_addr] = blk_din; end
                        else t.data = model_mem[blk_addr];
                    end
                    default: ;
                endcase
                if (g != K_IDLE && g != K_REFR) pend.push_back(t);
            end
            e_cs = 0; e_as = 0; e_ca = 0; e_ba = 0;
            for (int i = pend.size() - 1; i >= 0; i--) begin
                if (pend[i].due == cyc) begin
                    case (pend[i].kind)
                        K_CHAR: begin e_cs = 1; e_cd = pend[i].data; end
                        K_ATTR: begin e_as = 1; e_ad = pend[i].data; end
                        K_CPU: begin
                            e_ca = 1; m_cpu_wait = 0;
                            if (!pend[i].we) e_cpud = pend[i].data;
                        end
                        K_BLK: begin
                            e_ba = 1; m_blk_wait = 0;
                            if (!pend[i].we) e_blkd = pend[i].data;
                        end
                        default: ;
                    endcase
                    pend.delete(i);
                end
            end
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic checkOutput();
        checkVal("ram_addr", 32'(ram_addr), 32'(e_addr));
        checkVal("ram_we", 32'(ram_we), 32'(e_we));
        checkVal("ram_din", 32'(ram_din), 32'(e_din));
        checkVal("char_strobe", 32'(char_strobe), 32'(e_cs));
        checkVal("char_data", 32'(char_data), 32'(e_cd));
        checkVal("attr_strobe", 32'(attr_strobe), 32'(e_as));
        checkVal("attr_data", 32'(attr_data), 32'(e_ad));
        checkVal("cpu_ack", 32'(cpu_ack), 32'(e_ca));
        checkVal("cpu_dout", 32'(cpu_dout), 32'(e_cpud));
        checkVal("blk_ack", 32'(blk_ack), 32'(e_ba));
        checkVal("blk_dout", 32'(blk_dout), 32'(e_blkd));
    endtask

    task automatic stepCycle();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic waitCpuAck(input int budget, output int steps, output int wes,
                              output logic [7:0] wdin);
        steps = 0; wes = 0; wdin = '0;
        do begin
            stepCycle();
            steps++;
            if (ram_we) begin wes++; wdin = ram_din; end
        end while (!cpu_ack && steps < budget);
        checkVal("cpu_ack_seen", 32'(cpu_ack), 32'd1);
    endtask

    // One random cycle of display timing and requester behaviour
    task automatic applyStimulus();
        if (cpu_ack) cpu_req = 1'b0;
        else if (!cpu_req && $urandom_range(0, 3) == 0) begin
            cpu_req = 1'b1; cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_din = 8'($urandom);
        end
        if (blk_ack) blk_req = 1'b0;
        else if (!blk_req && $urandom_range(0, 2) == 0) begin
            blk_req = 1'b1; blk_we = 1'($urandom); blk_addr = 16'($urandom); blk_din = 8'($urandom);
        end
        enable     = ($urandom_range(0, 3) != 0);
        newCol     = ($urandom_range(0, 4) == 0);
        fetchCol   = 1'($urandom);
        hSyncStart = ($urandom_range(0, 40) == 0);
        reg_drr    = 4'($urandom);
        reg_atr    = 1'($urandom);
        char_addr  = 16'($urandom);
        attr_addr  = 16'($urandom);
        reset      = ($urandom_range(0, 300) == 0);
    endtask

    initial begin
        int steps, wes, ackSeq, altBad, nCpu, nBlk;
        logic [7:0] wdin;

        for (int i = 0; i < 65536; i++) begin
            ram_mem[i]   = pat(16'(i));
            model_mem[i] = pat(16'(i));
        end
        reset = 1'b1; enable = 1'b0; newCol = 1'b0; fetchCol = 1'b0; hSyncStart = 1'b0;
        reg_atr = 1'b0; reg_drr = 4'd0; char_addr = '0; attr_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
        blk_req = 1'b0; blk_we = 1'b0; blk_addr = '0; blk_din = '0;

        stepCycle();
        stepCycle();
        checkVal("reset_addr", 32'(ram_addr), 32'd0);
        checkVal("reset_ack", 32'(cpu_ack), 32'd0);

        reset = 1'b0; enable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            stepCycle();
            checkVal("idle_we", 32'(ram_we), 32'd0);
            checkVal("idle_addr", 32'(ram_addr), 32'd0);
        end

        $display("[TB] refresh burst with waiting CPU read");
        hSyncStart = 1'b1; reg_drr = 4'd5;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0042;
        for (int k = 0; k < 5; k++) begin
            stepCycle();
            hSyncStart = 1'b0;
            checkVal("refr_addr", 32'(ram_addr), 32'(k));
            checkVal("refr_we", 32'(ram_we), 32'd0);
        end
        waitCpuAck(20, steps, wes, wdin);
        checkVal("refr_cpu_wait", 32'(steps), 32'd3);
        checkVal("refr_cpu_dout", 32'(cpu_dout), 32'(pat(16'h0042)));
        cpu_req = 1'b0;

        $display("[TB] character and attribute fetch");
        newCol = 1'b1; fetchCol = 1'b1; reg_atr = 1'b1;
        char_addr = 16'h0010; attr_addr = 16'h0810;
        stepCycle();
        newCol = 1'b0; fetchCol = 1'b0;
        checkVal("char_addr", 32'(ram_addr), 32'h0010);
        stepCycle();
        checkVal("attr_addr", 32'(ram_addr), 32'h0810);
        stepCycle();
        checkVal("char_strobe_t2", 32'(char_strobe), 32'd1);
        checkVal("char_data_t2", 32'(char_data), 32'(pat(16'h0010)));
        stepCycle();
        checkVal("attr_strobe_t2", 32'(attr_strobe), 32'd1);
        checkVal("attr_data_t2", 32'(attr_data), 32'(pat(16'h0810)));
        reg_atr = 1'b0;
        stepCycle();
        checkVal("attr_strobe_end", 32'(attr_strobe), 32'd0);

        $display("[TB] CPU write then read back");
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_din = 8'hA5;
        waitCpuAck(20, steps, wes, wdin);
        checkVal("wr_we_pulses", 32'(wes), 32'd1);
        checkVal("wr_din", 32'(wdin), 32'hA5);
        cpu_req = 1'b0; cpu_we = 1'b0;
        stepCycle();
        cpu_req = 1'b1;
        waitCpuAck(20, steps, wes, wdin);
        checkVal("rd_we_pulses", 32'(wes), 32'd0);
        checkVal("rd_dout", 32'(cpu_dout), 32'hA5);
        cpu_req = 1'b0;

        $display("[TB] reset right after a CPU grant");
        cpu_req = 1'b1; cpu_addr = 16'h0300;
        stepCycle();
        checkVal("rg_addr", 32'(ram_addr), 32'h0300);
        reset = 1'b1;
        stepCycle();
        checkVal("rg_ack_dropped", 32'(cpu_ack), 32'd0);
        checkVal("rg_addr_cleared", 32'(ram_addr), 32'd0);
        reset = 1'b0;
        waitCpuAck(20, steps, wes, wdin);
        checkVal("rg_regrant_latency", 32'(steps), 32'd3);
        checkVal("rg_dout", 32'(cpu_dout), 32'(pat(16'h0300)));
        cpu_req = 1'b0;

        $display("[TB] CPU and block engine round robin");
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        cpu_req = 1'b1; cpu_addr = 16'h0100; blk_req = 1'b1; blk_we = 1'b0; blk_addr = 16'h0200;
        ackSeq = 0; altBad = 0; nCpu = 0; nBlk = 0;
        for (int k = 0; k < 18; k++) begin
            stepCycle();
            if (cpu_ack) begin
                if (ackSeq == K_CPU) altBad++;
                ackSeq = K_CPU; nCpu++;
            end
            if (blk_ack) begin
                if (ackSeq == K_BLK || nCpu == 0) altBad++;
                ackSeq = K_BLK; nBlk++;
            end
        end
        checkVal("rr_alternation", 32'(altBad), 32'd0);
        checkVal("rr_cpu_acks", 32'(nCpu), 32'd6);
        checkVal("rr_blk_acks", 32'(nBlk), 32'd5);
        cpu_req = 1'b0; blk_req = 1'b0;
        repeat (4) stepCycle();

        $display("[TB] random traffic");
        for (int i = 0; i < 2000; i++) begin
            stepCycle();
            applyStimulus();
        end
        reset = 1'b0; enable = 1'b1; newCol = 1'b0; hSyncStart = 1'b0;
        cpu_req = 1'b0; blk_req = 1'b0;
        repeat (24) stepCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
